// File: rtl/cu_pkg.sv
// cu_pkg: shared opcode, branch-code and FSM state definitions
package cu_pkg;

    localparam logic [5:0] OP_NOP    = 6'h00;
    localparam logic [5:0] OP_ALU    = 6'h01;
    localparam logic [5:0] OP_BRANCH = 6'h02;
    localparam logic [5:0] OP_CMOV   = 6'h03;
    localparam logic [5:0] OP_HALT   = 6'h3f;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_BR   = 3'b001;
    localparam logic [2:0] BR_BMI  = 3'b010;
    localparam logic [2:0] BR_BPL  = 3'b011;
    localparam logic [2:0] BR_BZ   = 3'b100;
    localparam logic [2:0] BR_CMOV = 3'b101;

    typedef enum logic [1:0] {
        FETCH_WAIT = 2'd0,
        EXEC       = 2'd1,
        BR_DONE    = 2'd2,
        HALTED     = 2'd3
    } state_t;

endpackage

// File: rtl/branch_cond.sv
// branch_cond: combinational branch-taken, CMOV and illegal-code evaluation
module branch_cond
    import cu_pkg::*;
(
    input  logic [2:0] branch_i,
    input  logic       flag_n_i,
    input  logic       flag_z_i,
    output logic       is_cond_o,
    output logic       taken_o,
    output logic       cmov_o,
    output logic       illegal_o
);

    assign is_cond_o = (branch_i != BR_NONE) && (branch_i <= BR_BZ);
    assign cmov_o    = (branch_i == BR_CMOV) && flag_n_i;
    assign illegal_o = branch_i[2] && branch_i[1];

    // condition evaluated against the flags as they stood before this cycle
    always_comb begin
        taken_o = (branch_i == BR_BR)  ? 1'b1 :
                  (branch_i == BR_BMI) ? flag_n_i :
                  (branch_i == BR_BPL) ? (!flag_n_i && !flag_z_i) :
                  (branch_i == BR_BZ)  ? flag_z_i : 1'b0;
    end

endmodule

// File: rtl/pc_branch_unit.sv
// pc_branch_unit: PC/IR/flags owner turning loadPC strobes into one fetch and one commit per instruction
module pc_branch_unit
    import cu_pkg::*;
#(
    parameter int unsigned         ADDR_W   = 32,
    parameter int unsigned         DATA_W   = 32,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0,
    parameter int unsigned         PC_INC   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              loadPC,
    input  logic [2:0]        branch,
    input  logic              halt,
    input  logic [31:0]       instr_in,
    input  logic [ADDR_W-1:0] imm_offset,
    input  logic              flags_we,
    input  logic [DATA_W-1:0] alu_result,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       ir,
    output logic              flag_n,
    output logic              flag_z,
    output logic              cmov_take,
    output logic              branch_taken,
    output logic              illegal_branch,
    output logic              halted,
    output logic [31:0]       retired
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, ir_pc_q, ir_pc_d;
    logic [31:0]       ir_q, ir_d, retired_q, retired_d;
    logic              flag_n_q, flag_n_d, flag_z_q, flag_z_d;
    logic              taken_q, taken_d, illegal_q, illegal_d;
    logic              is_cond, cond_taken, illegal_code;

    branch_cond u_cond (
        .branch_i  (branch),
        .flag_n_i  (flag_n_q),
        .flag_z_i  (flag_z_q),
        .is_cond_o (is_cond),
        .taken_o   (cond_taken),
        .cmov_o    (cmov_take),
        .illegal_o (illegal_code)
    );

    // next-state: fetch latch, single commit per instruction, halt freeze
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        ir_pc_d   = ir_pc_q;
        retired_d = retired_q;
        illegal_d = illegal_q;
        taken_d   = 1'b0;
        flag_n_d  = flag_n_q;
        flag_z_d  = flag_z_q;
        case (state_q)
            FETCH_WAIT: if (loadPC) begin
                ir_d    = instr_in;
                ir_pc_d = pc_q;
                state_d = EXEC;
            end
            EXEC: if (halt) begin
                state_d = HALTED;
            end else if (loadPC) begin
                retired_d = retired_q + 32'd1;
                taken_d   = is_cond && cond_taken;
                pc_d      = taken_d ? ir_pc_q + imm_offset : ir_pc_q + ADDR_W'(PC_INC);
                illegal_d = illegal_q || illegal_code;
                state_d   = is_cond ? BR_DONE : FETCH_WAIT;
            end
            BR_DONE: if (loadPC) state_d = FETCH_WAIT;
            default: ;
        endcase
        if (flags_we && state_q != HALTED) begin
            flag_z_d = (alu_result == '0);
            flag_n_d = alu_result[DATA_W-1];
        end
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH_WAIT;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            ir_pc_q   <= RESET_PC;
            retired_q <= '0;
            illegal_q <= 1'b0;
            taken_q   <= 1'b0;
            flag_n_q  <= 1'b0;
            flag_z_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            ir_pc_q   <= ir_pc_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
            taken_q   <= taken_d;
            flag_n_q  <= flag_n_d;
            flag_z_q  <= flag_z_d;
        end
    end

    assign pc             = pc_q;
    assign ir             = ir_q;
    assign flag_n         = flag_n_q;
    assign flag_z         = flag_z_q;
    assign branch_taken   = taken_q;
    assign illegal_branch = illegal_q;
    assign halted         = (state_q == HALTED);
    assign retired        = retired_q;

endmodule
